// File: rtl/sop_share_arbiter.sv
// Purpose: round-robin share of one sum-of-products engine between NREQ requesters, with result routing by tag.
// Latency: grant is combinational; operands reach the engine 1 cycle after issue; response is 1 cycle after the engine result.
// Backpressure: grants stop while DEPTH operations are in flight; requesters hold req until they see gnt.
//
// Ports:
//   clock, clock_areset_n        clock and asynchronous active-low reset
//   req / req_a / req_b          per-requester issue request and operand vectors
//   gnt                          one-hot combinational grant (issue when req[i] & gnt[i])
//   sop_data_valid/_dataa/_datab registered issue to the engine
//   sop_result_valid/sop_result  in-order result from the engine
//   rsp_valid / rsp_data         one-hot registered response strobe and shared result word
//   inflight                     issued but not yet returned operations
//   tag_err                      sticky: a result arrived with no owner recorded
module sop_share_arbiter #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = 1 + EXP + MANT,
  parameter int NUM   = 9,
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clock,
  input  logic                      clock_areset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*NUM*WIDTH-1:0] req_a,
  input  logic [NREQ*NUM*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]           gnt,
  output logic                      sop_data_valid,
  output logic [NUM*WIDTH-1:0]      sop_dataa,
  output logic [NUM*WIDTH-1:0]      sop_datab,
  input  logic                      sop_result_valid,
  input  logic [WIDTH-1:0]          sop_result,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [$clog2(DEPTH):0]    inflight,
  output logic                      tag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = NUM * WIDTH;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand_idx;
  logic           issue;
  logic           en;
  logic           pop;
  logic           fifo_empty;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [IDW-1:0] tag_mem [DEPTH];
  int             cand;

  // Pointers carry one extra bit, so their difference is the occupancy
  // directly and full (== DEPTH) is distinguishable from empty.
  assign inflight   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = sop_result_valid && !fifo_empty;

  // Reset is folded in so gnt reads 0 while reset is asserted even if req is high.
  // A pop in this cycle does not free a slot until the next cycle.
  assign en = clock_areset_n && (inflight < (AW+1)'(DEPTH));

  // Round-robin search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    cand_idx = '0;
    issue    = 1'b0;
    cand     = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        cand_idx = IDW'(cand);
        if (!issue && req[cand_idx]) begin
          issue         = 1'b1;
          gnt[cand_idx] = 1'b1;
          gnt_idx       = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      rr_ptr         <= '0;
      sop_data_valid <= 1'b0;
      sop_dataa      <= '0;
      sop_datab      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      tag_err        <= 1'b0;
    end else begin
      sop_data_valid <= issue;
      if (issue) begin
        sop_dataa <= req_a[gnt_idx*VW +: VW];
        sop_datab <= req_b[gnt_idx*VW +: VW];
        wr_ptr    <= wr_ptr + 1'b1;
        rr_ptr    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end

      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[tag_mem[rd_ptr[AW-1:0]]] <= 1'b1;
        rsp_data <= sop_result;
        rd_ptr   <= rd_ptr + 1'b1;
      end

      // A result with no recorded owner means engine and arbiter are out of step.
      if (sop_result_valid && fifo_empty) tag_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clock) begin
    if (issue) tag_mem[wr_ptr[AW-1:0]] <= gnt_idx;
  end

endmodule

// File: tb/tb_sop_share_arbiter.sv
module tb_sop_share_arbiter;

  localparam int EXP   = 8;
  localparam int MANT  = 7;
  localparam int WIDTH = 16;
  localparam int NUM   = 9;
  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 6;
  localparam int VW    = NUM * WIDTH;

  logic                   clock = 1'b0;
  logic                   clock_areset_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*VW-1:0]     req_a, req_b;
  logic [NREQ-1:0]        gnt;
  logic                   sop_data_valid;
  logic [VW-1:0]          sop_dataa, sop_datab;
  logic                   sop_result_valid;
  logic [WIDTH-1:0]       sop_result;
  logic [NREQ-1:0]        rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic [$clog2(DEPTH):0] inflight;
  logic                   tag_err;

  always #5 clock = ~clock;

  sop_share_arbiter #(.EXP(EXP), .MANT(MANT), .WIDTH(WIDTH), .NUM(NUM), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock(clock), .clock_areset_n(clock_areset_n),
    .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .sop_data_valid(sop_data_valid), .sop_dataa(sop_dataa), .sop_datab(sop_datab),
    .sop_result_valid(sop_result_valid), .sop_result(sop_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .tag_err(tag_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // bfloat16 arithmetic through reals; operands are kept in a range where this is exact enough.
  function automatic real bf2r(input logic [15:0] x);
    real m;
    int  e;
    if (x[14:7] == 8'd0) return 0.0;
    m = 1.0 + real'(x[6:0]) / 128.0;
    e = int'(x[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    real  a;
    int   e;
    int   mt;
    logic s;
    if (r == 0.0) return 16'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mt = int'($floor((a - 1.0) * 128.0));
    return {s, 8'(e + 127), 7'(mt)};
  endfunction

  function automatic logic [15:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    real s;
    s = 0.0;
    for (int i = 0; i < NUM; i++) s = s + bf2r(a[i*16 +: 16]) * bf2r(b[i*16 +: 16]);
    return r2bf(s);
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++)
      v[i*16 +: 16] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom_range(0, 127))};
    return v;
  endfunction

  // Requester operand state
  logic [VW-1:0] op_a [NREQ];
  logic [VW-1:0] op_b [NREQ];

  // Reference model: owner queue and expected registered outputs
  int             m_ptr;
  int             m_tags[$];
  logic [15:0]    m_vals[$];
  logic           exp_sdv;
  logic [VW-1:0]  exp_a, exp_b;
  logic [NREQ-1:0] exp_rspv;
  logic [15:0]    exp_rd;
  logic           exp_te;
  int             issues;
  int             cyc;

  // Engine: fixed latency, in order, results can be held back by a stall
  int             eng_due[$];
  logic [15:0]    eng_val[$];

  task automatic model_reset();
    m_ptr = 0; m_tags.delete(); m_vals.delete();
    exp_sdv = 1'b0; exp_a = '0; exp_b = '0; exp_rspv = '0; exp_rd = '0; exp_te = 1'b0;
    eng_due.delete(); eng_val.delete();
  endtask

  task automatic apply(input logic [NREQ-1:0] mask);
    req = mask;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*VW +: VW] = op_a[i];
      req_b[i*VW +: VW] = op_b[i];
    end
  endtask

  task automatic refresh(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++)
      if (g[i]) begin op_a[i] = rand_vec(); op_b[i] = rand_vec(); end
  endtask

  // One cycle: called at a falling edge with req already applied; returns at the next falling edge.
  task automatic tick(input bit stall, input bit inject, output logic [NREQ-1:0] granted);
    logic [NREQ-1:0] mg;
    int gi;
    int idx;
    int t;
    sop_result_valid = 1'b0;
    sop_result       = '0;
    if (inject) begin
      sop_result_valid = 1'b1;
      sop_result       = 16'($urandom);
    end else if (!stall && eng_due.size() > 0 && eng_due[0] <= cyc) begin
      sop_result_valid = 1'b1;
      sop_result       = eng_val.pop_front();
      void'(eng_due.pop_front());
    end
    #1;
    mg = '0;
    gi = -1;
    if (m_tags.size() < DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (gi < 0 && req[idx]) gi = idx;
      end
    if (gi >= 0) mg[gi] = 1'b1;

    chk("gnt", gnt, mg);
    chk("sop_data_valid", sop_data_valid, exp_sdv);
    chk("sop_dataa", sop_dataa, exp_a);
    chk("sop_datab", sop_datab, exp_b);
    chk("rsp_valid", rsp_valid, exp_rspv);
    chk("rsp_data", rsp_data, exp_rd);
    chk("inflight", inflight, m_tags.size());
    chk("tag_err", tag_err, exp_te);
    granted = req & gnt;

    if (sop_data_valid) begin
      eng_due.push_back(cyc + LAT);
      eng_val.push_back(dot(sop_dataa, sop_datab));
    end

    exp_rspv = '0;
    if (sop_result_valid) begin
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        exp_rspv[t] = 1'b1;
        exp_rd = m_vals.pop_front();
      end else begin
        exp_te = 1'b1;
      end
    end
    if (gi >= 0) begin
      exp_sdv = 1'b1;
      exp_a   = req_a[gi*VW +: VW];
      exp_b   = req_b[gi*VW +: VW];
      m_tags.push_back(gi);
      m_vals.push_back(dot(exp_a, exp_b));
      m_ptr = (gi + 1) % NREQ;
      issues++;
    end else begin
      exp_sdv = 1'b0;
    end

    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] cur;
    logic [VW-1:0]   ones;
    int  c0;
    bit  got;

    clock_areset_n = 1'b0;
    req = '0; req_a = '0; req_b = '0;
    sop_result_valid = 1'b0; sop_result = '0;
    cyc = 0; issues = 0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = rand_vec(); op_b[i] = rand_vec(); end
    model_reset();

    repeat (3) @(negedge clock);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sdv", sop_data_valid, 0);
    chk("rst_dataa", sop_dataa, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_tag_err", tag_err, 0);
    clock_areset_n = 1'b1;
    @(negedge clock);

    // Single issue with all-1.0 vectors: 9.0 in bfloat16, 8 cycles issue to response
    ones = {NUM{16'h3F80}};
    op_a[0] = ones; op_b[0] = ones;
    apply(4'b0001);
    c0 = cyc;
    tick(0, 0, g);
    chk("a_gnt", g, 4'b0001);
    refresh(g);
    apply(4'b0000);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rsp_valid != 0) begin
        got = 1;
        chk("a_latency", cyc - c0, 8);
        chk("a_rspv", rsp_valid, 4'b0001);
        chk("a_rspd", rsp_data, 16'h4110);
      end else begin
        tick(0, 0, g);
      end
    end
    if (!got) chk("a_timeout", 0, 1);

    // Move the pointer back to 0, then all four requesting for 8 cycles
    apply(4'b1000); tick(0, 0, g); refresh(g);
    for (int k = 0; k < 8; k++) begin
      apply(4'b1111);
      tick(0, 0, g);
      chk("b_order", g, 4'b0001 << (k % 4));
      refresh(g);
    end
    apply(4'b0000);
    repeat (12) tick(0, 0, g);

    // Pointer at 2 with req 0011: wrap to 0, then 1
    apply(4'b0010); tick(0, 0, g); refresh(g);
    apply(4'b0011); tick(0, 0, g); chk("c_wrap0", g, 4'b0001); refresh(g);
    apply(4'b0011); tick(0, 0, g); chk("c_next1", g, 4'b0010); refresh(g);
    apply(4'b0000);
    repeat (12) tick(0, 0, g);

    // Results held back: issue stops at DEPTH, one release gives exactly one more issue
    issues = 0;
    for (int k = 0; k < DEPTH + 8; k++) begin
      apply(4'b0001); tick(1, 0, g); refresh(g);
    end
    chk("d_issues", issues, DEPTH);
    apply(4'b0001);
    #1;
    chk("d_gnt_full", gnt, 0);
    chk("d_inflight_full", inflight, DEPTH);
    issues = 0;
    tick(0, 0, g); refresh(g);
    chk("d_no_issue_on_pop", issues, 0);
    apply(4'b0001); tick(1, 0, g); refresh(g);
    chk("d_one_reissue", issues, 1);
    for (int k = 0; k < 3; k++) begin
      apply(4'b0001); tick(1, 0, g); refresh(g);
    end
    chk("d_still_one", issues, 1);
    apply(4'b0000);
    repeat (DEPTH + LAT + 6) tick(0, 0, g);

    // Continuous push and pop: occupancy settles at LAT+1 and pointers wrap
    for (int k = 0; k < 40; k++) begin
      apply(4'b0100); tick(0, 0, g); refresh(g);
    end
    chk("e_inflight_steady", inflight, LAT + 1);
    chk("e_tag_err", tag_err, 0);
    apply(4'b0000);
    repeat (LAT + 6) tick(0, 0, g);

    // Stray result with nothing in flight
    tick(0, 1, g);
    chk("f_tag_err", tag_err, 1);
    chk("f_no_rsp", rsp_valid, 0);

    // Reset while 5 operations are outstanding
    for (int k = 0; k < 20 && m_tags.size() < 5; k++) begin
      apply(4'b0001); tick(1, 0, g); refresh(g);
    end
    chk("f_inflight5", inflight, 5);
    #2;
    clock_areset_n = 1'b0;
    #1;
    chk("f_rst_gnt", gnt, 0);
    chk("f_rst_sdv", sop_data_valid, 0);
    chk("f_rst_dataa", sop_dataa, 0);
    chk("f_rst_datab", sop_datab, 0);
    chk("f_rst_rspv", rsp_valid, 0);
    chk("f_rst_rspd", rsp_data, 0);
    chk("f_rst_inflight", inflight, 0);
    chk("f_rst_tag_err", tag_err, 0);
    apply(4'b0000);
    @(negedge clock);
    clock_areset_n = 1'b1;
    model_reset();
    tick(0, 0, g);
    chk("f_post_inflight", inflight, 0);

    // Random traffic with random result stalls
    cur = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!cur[i] && $urandom_range(0, 1) == 1) cur[i] = 1'b1;
      apply(cur);
      tick($urandom_range(0, 3) == 0, 0, g);
      refresh(g);
      cur = cur & ~g;
    end
    apply(4'b0000);
    repeat (DEPTH + LAT + 10) tick(0, 0, g);
    chk("r_drained", inflight, 0);
    chk("r_tag_err", tag_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
